// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
//
// Registered, flow-controlled accumulation stage behind the unsigned Booth
// multiplier. The block takes 2N-bit products over a valid/ready handshake and
// adds them into a saturating frame sum (dot product). A frame ends on the beat
// that carries prod_last. The result is then held until the consumer takes it.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous frame abort; clears the accumulator
//   prod_in    in   2*N    unsigned product from the multiplier
//   prod_valid in   1      prod_in is valid
//   prod_last  in   1      prod_in is the final term of the frame
//   prod_ready out  1      a product can be accepted this cycle
//   acc_out    out  ACC_W  saturated frame sum
//   acc_cnt    out  CNT_W  number of terms in the frame (saturating)
//   acc_ovf    out  1      the frame sum saturated at some point in the frame
//   acc_valid  out  1      acc_out/acc_cnt/acc_ovf hold a finished frame
//   acc_ready  in   1      consumer accepts the result
module booth_product_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 2*N+4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [2*N-1:0]   prod_in,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] acc_cnt,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   accSum_q;
  logic [ACC_W-1:0]   accSum_d;
  logic [CNT_W-1:0]   termCnt_q;
  logic [CNT_W-1:0]   termCnt_d;
  logic               ovf_q;
  logic               ovf_d;
  logic               resValid_q;
  logic               first_q;
  logic [ACC_W-1:0]   base;
  logic [ACC_W:0]     sum;
  logic               beat;

  // prod_ready is decoded straight from the state so a producer sees it
  // without an extra cycle of latency.
  assign prod_ready = (state_q == ACCUM);
  assign beat       = prod_valid & prod_ready;

  // One extra bit on the sum exposes the carry that signals saturation.
  // The first beat of a frame starts from zero instead of the stale result,
  // which is why the previous result can be left in place after hand-off.
  always_comb begin
    base     = first_q ? '0 : accSum_q;
    sum      = {1'b0, base} + {{(ACC_W+1-2*N){1'b0}}, prod_in};
    accSum_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    ovf_d    = (first_q ? 1'b0 : ovf_q) | sum[ACC_W];
    if (first_q) begin
      termCnt_d = CNT_W'(1);
    end else if (&termCnt_q) begin
      termCnt_d = termCnt_q;
    end else begin
      termCnt_d = termCnt_q + CNT_W'(1);
    end
  end

  // clear wins over every handshake and returns the block to its reset state,
  // dropping any beat offered in the same cycle and any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      accSum_q   <= '0;
      termCnt_q  <= '0;
      ovf_q      <= 1'b0;
      resValid_q <= 1'b0;
      first_q    <= 1'b1;
    end else if (clear) begin
      state_q    <= ACCUM;
      accSum_q   <= '0;
      termCnt_q  <= '0;
      ovf_q      <= 1'b0;
      resValid_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat) begin
            accSum_q  <= accSum_d;
            termCnt_q <= termCnt_d;
            ovf_q     <= ovf_d;
            first_q   <= 1'b0;
            if (prod_last) begin
              state_q    <= HOLD;
              resValid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Result registers keep their value; the next frame's first beat
          // overwrites them.
          if (acc_ready) begin
            state_q    <= ACCUM;
            resValid_q <= 1'b0;
            first_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign acc_out   = accSum_q;
  assign acc_cnt   = termCnt_q;
  assign acc_ovf   = ovf_q;
  assign acc_valid = resValid_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Testbench for booth_product_accumulator (N=4, ACC_W=12, CNT_W=8).
// Frames are built from products of 4-bit operands; the expected frame result
// is computed with integer arithmetic when the frame is queued, and compared
// when the DUT hands a result over on acc_valid & acc_ready.
module tb_booth_product_accumulator;

  localparam int N     = 4;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;
  localparam int SAT   = 4095;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
  } expT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clear = 1'b0;
  logic [2*N-1:0]   prod_in = '0;
  logic             prod_valid = 1'b0;
  logic             prod_last = 1'b0;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_ovf;
  logic             acc_valid;
  logic             acc_ready = 1'b0;

  expT expQ[$];
  int  frameQ[$];
  int  testsRun = 0;
  int  testsFailed = 0;
  int  acceptCount = 0;
  bit  randReady = 1'b0;

  booth_product_accumulator #(
    .N(N),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .prod_in(prod_in),
    .prod_valid(prod_valid),
    .prod_last(prod_last),
    .prod_ready(prod_ready),
    .acc_out(acc_out),
    .acc_cnt(acc_cnt),
    .acc_ovf(acc_ovf),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference: saturating running sum, sticky overflow, saturating term count.
  task automatic pushExpected();
    expT e;
    int  s;
    bit  o;
    s = 0;
    o = 1'b0;
    foreach (frameQ[i]) begin
      if (s + frameQ[i] > SAT) begin
        s = SAT;
        o = 1'b1;
      end else begin
        s = s + frameQ[i];
      end
    end
    e.sum = s;
    e.cnt = (frameQ.size() > 255) ? 255 : frameQ.size();
    e.ovf = o;
    expQ.push_back(e);
  endtask

  // Called just after a falling edge with inputs already set: records the
  // handshakes that the next rising edge will perform, then advances one cycle.
  task automatic clockCycle(output bit accepted);
    expT e;
    if (randReady) acc_ready = ($urandom_range(0, 3) != 0);
    accepted = prod_valid && prod_ready && !clear;
    if (accepted) acceptCount++;
    if (acc_valid && acc_ready && !clear) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_acc_out", 32'(acc_out), 32'(e.sum));
        checkOutput("sb_acc_cnt", 32'(acc_cnt), 32'(e.cnt));
        checkOutput("sb_acc_ovf", 32'(acc_ovf), 32'(e.ovf));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendBeat(input int data, input bit last, input bit randValid);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    prod_in = data[2*N-1:0];
    prod_last = last;
    while (!acc) begin
      prod_valid = randValid ? ($urandom_range(0, 3) != 0) : 1'b1;
      clockCycle(acc);
      budget++;
      if (!acc && budget >= 200) begin
        checkOutput("beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    prod_valid = 1'b0;
    prod_last = 1'b0;
  endtask

  task automatic applyStimulus(input bit randValid);
    pushExpected();
    foreach (frameQ[i]) sendBeat(frameQ[i], (i == frameQ.size() - 1), randValid);
  endtask

  initial begin
    bit ok;
    int len;
    int opA;
    int opB;
    bit hot;
    int budget;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(acc_valid), 32'd0);
    checkOutput("rst_ready", 32'(prod_ready), 32'd1);
    checkOutput("rst_out", 32'(acc_out), 32'd0);
    checkOutput("rst_cnt", 32'(acc_cnt), 32'd0);
    checkOutput("rst_ovf", 32'(acc_ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame discards the partial sum.
    acc_ready = 1'b1;
    sendBeat(15, 1'b0, 1'b0);
    checkOutput("mid_out_before", 32'(acc_out), 32'd15);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out", 32'(acc_out), 32'd0);
    checkOutput("mid_rst_cnt", 32'(acc_cnt), 32'd0);
    checkOutput("mid_rst_ready", 32'(prod_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a result is held drops acc_valid without a clock edge.
    acc_ready = 1'b0;
    frameQ = '{33};
    applyStimulus(1'b0);
    checkOutput("hold_valid_before", 32'(acc_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("hold_rst_valid", 32'(acc_valid), 32'd0);
    checkOutput("hold_rst_out", 32'(acc_out), 32'd0);
    checkOutput("hold_rst_ready", 32'(prod_ready), 32'd1);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame 15 + 14 + 225.
    acc_ready = 1'b1;
    frameQ = '{15, 14, 225};
    applyStimulus(1'b0);
    checkOutput("f1_latency_valid", 32'(acc_valid), 32'd1);
    checkOutput("f1_out", 32'(acc_out), 32'd254);
    checkOutput("f1_cnt", 32'(acc_cnt), 32'd3);
    checkOutput("f1_ovf", 32'(acc_ovf), 32'd0);
    checkOutput("f1_hold_ready", 32'(prod_ready), 32'd0);
    clockCycle(ok);
    checkOutput("f1_release_valid", 32'(acc_valid), 32'd0);
    checkOutput("f1_release_ready", 32'(prod_ready), 32'd1);

    // Saturation, then a single-beat frame starts fresh.
    frameQ.delete();
    repeat (19) frameQ.push_back(225);
    applyStimulus(1'b0);
    checkOutput("sat_out", 32'(acc_out), 32'd4095);
    checkOutput("sat_cnt", 32'(acc_cnt), 32'd19);
    checkOutput("sat_ovf", 32'(acc_ovf), 32'd1);
    clockCycle(ok);
    frameQ = '{9};
    applyStimulus(1'b0);
    checkOutput("single_out", 32'(acc_out), 32'd9);
    checkOutput("single_cnt", 32'(acc_cnt), 32'd1);
    checkOutput("single_ovf", 32'(acc_ovf), 32'd0);
    clockCycle(ok);

    // Backpressure: result held while the next beat waits.
    acc_ready = 1'b0;
    frameQ = '{5, 6};
    applyStimulus(1'b0);
    frameQ = '{77};
    pushExpected();
    prod_in = 8'd77;
    prod_last = 1'b1;
    prod_valid = 1'b1;
    acceptCount = 0;
    repeat (10) begin
      checkOutput("bp_ready", 32'(prod_ready), 32'd0);
      checkOutput("bp_valid", 32'(acc_valid), 32'd1);
      checkOutput("bp_out", 32'(acc_out), 32'd11);
      checkOutput("bp_cnt", 32'(acc_cnt), 32'd2);
      clockCycle(ok);
    end
    acc_ready = 1'b1;
    clockCycle(ok);
    checkOutput("bp_back_to_accum", 32'(prod_ready), 32'd1);
    clockCycle(ok);
    checkOutput("bp_pending_taken", 32'(ok), 32'd1);
    prod_valid = 1'b0;
    prod_last = 1'b0;
    clockCycle(ok);
    checkOutput("bp_accept_once", 32'(acceptCount), 32'd1);

    // Clear mid-frame drops the partial sum and the beat offered with it.
    sendBeat(10, 1'b0, 1'b0);
    sendBeat(20, 1'b0, 1'b0);
    checkOutput("clr_partial", 32'(acc_out), 32'd30);
    clear = 1'b1;
    prod_valid = 1'b1;
    prod_in = 8'd30;
    prod_last = 1'b1;
    clockCycle(ok);
    clear = 1'b0;
    prod_valid = 1'b0;
    prod_last = 1'b0;
    checkOutput("clr_out", 32'(acc_out), 32'd0);
    checkOutput("clr_cnt", 32'(acc_cnt), 32'd0);
    checkOutput("clr_valid", 32'(acc_valid), 32'd0);
    checkOutput("clr_ready", 32'(prod_ready), 32'd1);
    clockCycle(ok);
    checkOutput("clr_no_result", 32'(acc_valid), 32'd0);
    frameQ = '{4};
    applyStimulus(1'b0);
    checkOutput("clr_next_out", 32'(acc_out), 32'd4);
    checkOutput("clr_next_cnt", 32'(acc_cnt), 32'd1);
    clockCycle(ok);

    // Clear while holding discards the result.
    acc_ready = 1'b0;
    frameQ = '{50};
    applyStimulus(1'b0);
    checkOutput("clrh_valid_before", 32'(acc_valid), 32'd1);
    clear = 1'b1;
    clockCycle(ok);
    clear = 1'b0;
    expQ.delete();
    checkOutput("clrh_valid", 32'(acc_valid), 32'd0);
    checkOutput("clrh_out", 32'(acc_out), 32'd0);
    checkOutput("clrh_ready", 32'(prod_ready), 32'd1);
    acc_ready = 1'b1;

    // Random frames with stalls on both sides; some frames use large
    // operands so that saturation is reached.
    randReady = 1'b1;
    for (int f = 0; f < 2000; f++) begin
      frameQ.delete();
      len = $urandom_range(1, 20);
      hot = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < len; k++) begin
        opA = hot ? $urandom_range(12, 15) : $urandom_range(0, 15);
        opB = hot ? $urandom_range(12, 15) : $urandom_range(0, 15);
        frameQ.push_back(opA * opB);
      end
      applyStimulus(1'b1);
    end
    randReady = 1'b0;
    acc_ready = 1'b1;
    budget = 0;
    while (expQ.size() != 0 && budget < 100) begin
      clockCycle(ok);
      budget++;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
